// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern, length and overlap mode.
// Produces a Mealy match pulse and keeps a saturating match count.
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         din,
    input  logic                         din_valid,
    input  logic                         cfg_load,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    output logic                         dout,
    output logic [CNT_W-1:0]             match_cnt,
    output logic                         cnt_sat
);

    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int FILL_W  = $clog2(MAX_LEN);
    // The reset pattern is 110110; narrow instances keep only its low bits.
    localparam int DEF_LEN = (MAX_LEN < 6) ? MAX_LEN : 6;
    localparam logic [31:0]        DEF_PAT  = 32'b110110;
    localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(MAX_LEN - 1);
    localparam logic [CNT_W-1:0]   CNT_ALL  = {CNT_W{1'b1}};

    logic [MAX_LEN-1:0] pattern_r;
    logic [LEN_W-1:0]   len_r;
    logic               overlap_r;
    logic [MAX_LEN-2:0] hist_r;
    logic [FILL_W-1:0]  fill_r;
    logic [CNT_W-1:0]   match_cnt_r;
    logic               cnt_sat_r;

    logic [MAX_LEN-1:0] window_s;
    logic [MAX_LEN-1:0] mask_s;
    logic               sample_s;
    logic               armed_s;
    logic               hit_s;
    logic [CNT_W-1:0]   cnt_next_s;

    // Match decision: compare the newest len bits (history plus current din) to the pattern.
    always_comb begin
        window_s = {hist_r, din};
        mask_s   = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask_s[i] = (LEN_W'(i) < len_r);
        end
        sample_s = din_valid & ~cfg_load;
        if (len_r >= LEN_W'(2)) begin
            armed_s = (LEN_W'(fill_r) >= (len_r - LEN_W'(1)));
        end else begin
            armed_s = 1'b0;
        end
        hit_s = rst_n & sample_s & armed_s & (((window_s ^ pattern_r) & mask_s) == '0);
    end

    // Next value of the saturating match counter.
    always_comb begin
        if (hit_s && (match_cnt_r != CNT_ALL)) begin
            cnt_next_s = match_cnt_r + CNT_W'(1);
        end else begin
            cnt_next_s = match_cnt_r;
        end
    end

    // Configuration, history and fill tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_r <= DEF_PAT[MAX_LEN-1:0];
            len_r     <= LEN_W'(DEF_LEN);
            overlap_r <= 1'b1;
            hist_r    <= '0;
            fill_r    <= '0;
        end else if (cfg_load) begin
            pattern_r <= cfg_pattern;
            len_r     <= (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
            overlap_r <= cfg_overlap;
            hist_r    <= '0;
            fill_r    <= '0;
        end else if (din_valid) begin
            hist_r <= window_s[MAX_LEN-2:0];
            // Non-overlapping mode forces the next match to collect a full fresh pattern.
            if (hit_s && !overlap_r) begin
                fill_r <= '0;
            end else if (fill_r != FILL_MAX) begin
                fill_r <= fill_r + FILL_W'(1);
            end else begin
                fill_r <= fill_r;
            end
        end else begin
            hist_r <= hist_r;
            fill_r <= fill_r;
        end
    end

    // Match counter and its registered saturation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt_r <= '0;
            cnt_sat_r   <= 1'b0;
        end else begin
            match_cnt_r <= cnt_next_s;
            cnt_sat_r   <= (cnt_next_s == CNT_ALL);
        end
    end

    assign dout      = hit_s;
    assign match_cnt = match_cnt_r;
    assign cnt_sat   = cnt_sat_r;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: three instances (MAX_LEN 8/4/32) run the same
// serial stream while a behavioural model predicts every dout and the match counters.
module tb_seq_detector_param;

    logic        clk;
    logic        rst_n;
    logic        din;
    logic        din_valid;
    logic        cfg_load;
    logic        cfg_overlap;
    logic [7:0]  cfg_pattern8;
    logic [3:0]  cfg_len8;
    logic [3:0]  cfg_pattern4;
    logic [2:0]  cfg_len4;
    logic [31:0] cfg_pattern32;
    logic [5:0]  cfg_len32;
    logic        dout8, dout4, dout32;
    logic [15:0] match_cnt8, match_cnt32;
    logic [2:0]  match_cnt4;
    logic        cnt_sat8, cnt_sat4, cnt_sat32;

    int          n_assert;
    int          n_fail;
    logic [31:0] hits;
    logic [2:0]  sb_q[$];

    logic [31:0] m_pat  [3];
    logic [31:0] m_hist [3];
    int          m_len  [3];
    int          m_fill [3];
    logic        m_ovl  [3];
    longint      m_cnt  [3];

    seq_detector_param #(.MAX_LEN(8), .CNT_W(16)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern8), .cfg_len(cfg_len8), .cfg_overlap(cfg_overlap),
        .dout(dout8), .match_cnt(match_cnt8), .cnt_sat(cnt_sat8));

    seq_detector_param #(.MAX_LEN(4), .CNT_W(3)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern4), .cfg_len(cfg_len4), .cfg_overlap(cfg_overlap),
        .dout(dout4), .match_cnt(match_cnt4), .cnt_sat(cnt_sat4));

    seq_detector_param #(.MAX_LEN(32), .CNT_W(16)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern32), .cfg_len(cfg_len32), .cfg_overlap(cfg_overlap),
        .dout(dout32), .match_cnt(match_cnt32), .cnt_sat(cnt_sat32));

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ml(input int m);
        case (m)
            0:       return 8;
            1:       return 4;
            default: return 32;
        endcase
    endfunction

    function automatic longint cmax(input int m);
        return (m == 1) ? 64'd7 : 64'd65535;
    endfunction

    function automatic logic [31:0] pmask(input int m);
        logic [63:0] w;
        w = (64'd1 << ml(m)) - 64'd1;
        return w[31:0];
    endfunction

    function automatic logic [31:0] cfg_p(input int m);
        case (m)
            0:       return {24'd0, cfg_pattern8};
            1:       return {28'd0, cfg_pattern4};
            default: return cfg_pattern32;
        endcase
    endfunction

    function automatic int cfg_l(input int m);
        case (m)
            0:       return int'(cfg_len8);
            1:       return int'(cfg_len4);
            default: return int'(cfg_len32);
        endcase
    endfunction

    function automatic logic obs_dout(input int m);
        case (m)
            0:       return dout8;
            1:       return dout4;
            default: return dout32;
        endcase
    endfunction

    function automatic longint obs_cnt(input int m);
        case (m)
            0:       return longint'(match_cnt8);
            1:       return longint'(match_cnt4);
            default: return longint'(match_cnt32);
        endcase
    endfunction

    function automatic logic obs_sat(input int m);
        case (m)
            0:       return cnt_sat8;
            1:       return cnt_sat4;
            default: return cnt_sat32;
        endcase
    endfunction

    function automatic void model_reset();
        for (int m = 0; m < 3; m++) begin
            m_pat[m]  = 32'b110110 & pmask(m);
            m_len[m]  = (ml(m) < 6) ? ml(m) : 6;
            m_ovl[m]  = 1'b1;
            m_hist[m] = 32'd0;
            m_fill[m] = 0;
            m_cnt[m]  = 0;
        end
    endfunction

    // Predicted dout from the model state before the clock edge.
    function automatic logic model_dout(input int m, input logic d, input logic v, input logic ld);
        logic ok;
        if (!v || ld || m_len[m] < 2 || m_fill[m] < m_len[m] - 1) return 1'b0;
        ok = (d == m_pat[m][0]);
        for (int k = 1; k < m_len[m]; k++) begin
            if (m_hist[m][k-1] != m_pat[m][k]) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic void model_update(input int m, input logic d, input logic v,
                                         input logic ld, input logic hit);
        logic [63:0] hm;
        logic [63:0] nh;
        if (ld) begin
            m_pat[m]  = cfg_p(m);
            m_len[m]  = (cfg_l(m) > ml(m)) ? ml(m) : cfg_l(m);
            m_ovl[m]  = cfg_overlap;
            m_hist[m] = 32'd0;
            m_fill[m] = 0;
        end else if (v) begin
            hm = (64'd1 << (ml(m) - 1)) - 64'd1;
            nh = ({32'd0, m_hist[m]} << 1 | {63'd0, d}) & hm;
            m_hist[m] = nh[31:0];
            if (hit && !m_ovl[m]) m_fill[m] = 0;
            else if (m_fill[m] < ml(m) - 1) m_fill[m]++;
            if (hit && m_cnt[m] < cmax(m)) m_cnt[m]++;
        end
    endfunction

    task automatic step(input logic d, input logic v, input logic ld);
        logic [2:0] exp_s;
        logic [2:0] got_s;
        din = d; din_valid = v; cfg_load = ld;
        for (int m = 0; m < 3; m++) exp_s[m] = model_dout(m, d, v, ld);
        sb_q.push_back(exp_s);
        for (int m = 0; m < 3; m++) model_update(m, d, v, ld, exp_s[m]);
        @(negedge clk);
        got_s = sb_q.pop_front();
        chk_eq("dout8",  {63'd0, dout8},  {63'd0, got_s[0]});
        chk_eq("dout4",  {63'd0, dout4},  {63'd0, got_s[1]});
        chk_eq("dout32", {63'd0, dout32}, {63'd0, got_s[2]});
        if (v && !ld) hits = {hits[30:0], dout8};
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnts(input string tag);
        for (int m = 0; m < 3; m++) begin
            chk_eq({tag, "_cnt"}, obs_cnt(m), m_cnt[m]);
            chk_eq({tag, "_sat"}, {63'd0, obs_sat(m)}, {63'd0, (m_cnt[m] == cmax(m))});
        end
    endtask

    task automatic do_reset();
        din = 1'b1; din_valid = 1'b1; cfg_load = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_eq("rst_dout8",  {63'd0, dout8},  64'd0);
        chk_eq("rst_dout32", {63'd0, dout32}, 64'd0);
        chk_eq("rst_cnt8",   {48'd0, match_cnt8}, 64'd0);
        chk_eq("rst_sat8",   {63'd0, cnt_sat8}, 64'd0);
        din_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    // Load one configuration into all instances, then scramble the cfg inputs.
    task automatic load(input logic [31:0] p, input int l8, input int l4, input int l32,
                        input logic ov);
        cfg_pattern8 = p[7:0];  cfg_len8  = 4'(l8);
        cfg_pattern4 = p[3:0];  cfg_len4  = 3'(l4);
        cfg_pattern32 = p;      cfg_len32 = 6'(l32);
        cfg_overlap = ov;
        step(1'b1, 1'b1, 1'b1);
        cfg_pattern8 = 8'($urandom()); cfg_len8 = 4'($urandom());
        cfg_pattern4 = 4'($urandom()); cfg_len4 = 3'($urandom());
        cfg_pattern32 = $urandom();    cfg_len32 = 6'($urandom());
        cfg_overlap = 1'($urandom());
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            step(bits[i], 1'b1, 1'b0);
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [31:0] p;
        logic        b;
        logic        v;
        logic        ov;
        int          pl;
        int          k;
        n_assert = 0; n_fail = 0; hits = 32'd0;
        clk = 1'b0; rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; cfg_load = 1'b0;
        cfg_overlap = 1'b0;
        cfg_pattern8 = 8'd0; cfg_len8 = 4'd0; cfg_pattern4 = 4'd0; cfg_len4 = 3'd0;
        cfg_pattern32 = 32'd0; cfg_len32 = 6'd0;
        model_reset();
        @(posedge clk);
        #1;

        do_reset();
        check_cnts("reset");

        hits = 32'd0;
        send_bits(32'b110110110, 9, 0);
        chk_eq("ovl_hits", {32'd0, hits}, 64'h009);
        chk_eq("ovl_cnt8", {48'd0, match_cnt8}, 64'd2);
        check_cnts("ovl");

        do_reset();
        load(32'b110110, 6, 6, 6, 1'b0);
        hits = 32'd0;
        send_bits(32'b110110110, 9, 0);
        chk_eq("novl_hits", {32'd0, hits}, 64'h008);
        chk_eq("novl_cnt8", {48'd0, match_cnt8}, 64'd1);
        check_cnts("novl");

        do_reset();
        load(32'b101, 3, 3, 3, 1'b1);
        hits = 32'd0;
        send_bits(32'b10101, 5, 2);
        chk_eq("gap_hits", {32'd0, hits}, 64'h005);
        chk_eq("gap_cnt8", {48'd0, match_cnt8}, 64'd2);
        check_cnts("gap");

        do_reset();
        load(32'b11, 2, 2, 2, 1'b1);
        send_bits(32'h7f, 7, 0);
        chk_eq("sat_cnt4_6", {61'd0, match_cnt4}, 64'd6);
        chk_eq("sat_flag_0", {63'd0, cnt_sat4}, 64'd0);
        send_bits(32'h7, 3, 0);
        chk_eq("sat_cnt4_7", {61'd0, match_cnt4}, 64'd7);
        chk_eq("sat_flag_1", {63'd0, cnt_sat4}, 64'd1);
        chk_eq("sat_cnt8",   {48'd0, match_cnt8}, 64'd9);
        check_cnts("sat");

        do_reset();
        send_bits(32'b11011, 5, 0);
        do_reset();
        hits = 32'd0;
        send_bits(32'b0110110, 7, 0);
        chk_eq("midrst_hits", {32'd0, hits}, 64'h001);
        chk_eq("midrst_cnt8", {48'd0, match_cnt8}, 64'd1);

        send_bits(32'b11011, 5, 0);
        load(32'b110110, 6, 6, 6, 1'b1);
        hits = 32'd0;
        send_bits(32'b0110110, 7, 0);
        chk_eq("midld_hits", {32'd0, hits}, 64'h001);
        check_cnts("mid");

        // Random streams over every length, each segment biased toward one instance's pattern.
        for (int L = 0; L <= 33; L++) begin
            p  = $urandom();
            ov = 1'($urandom_range(0, 1));
            load(p, L % 10, L % 6, L, ov);
            for (int s = 0; s < 3; s++) begin
                pl = m_len[s];
                if (pl < 2) pl = 2;
                k = 0;
                for (int t = 0; t < 24; t++) begin
                    v = ($urandom_range(0, 3) != 0);
                    b = p[pl - 1 - (k % pl)];
                    if ($urandom_range(0, 9) == 0) b = ~b;
                    if (v) k++;
                    step(b, v, 1'b0);
                end
            end
            check_cnts("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
